// File: rtl/ifft_result_reader_pkg.sv
// Shared definitions for the IFFT result reader: FSM state encoding,
// default bin geometry and the real/imag field layout of a bin word.
package ifft_result_reader_pkg;

  localparam int BIN_ADDR_W = 9;
  localparam int BIN_DATA_W = 36;

  // Bin word layout: {real, imag}, both two's complement.
  localparam int REAL_MSB = 35;
  localparam int REAL_LSB = 18;
  localparam int IMAG_MSB = 17;
  localparam int IMAG_LSB = 0;

  // One-hot so every state decode is a single flop bit.
  typedef enum logic [4:0] {
    S_IDLE = 5'b00001,
    S_REQ  = 5'b00010,
    S_WAIT = 5'b00100,
    S_PUSH = 5'b01000,
    S_DONE = 5'b10000
  } state_e;

  function automatic logic signed [REAL_MSB-REAL_LSB:0] bin_real(input logic [BIN_DATA_W-1:0] w);
    return w[REAL_MSB:REAL_LSB];
  endfunction

  function automatic logic signed [IMAG_MSB-IMAG_LSB:0] bin_imag(input logic [BIN_DATA_W-1:0] w);
    return w[IMAG_MSB:IMAG_LSB];
  endfunction

endpackage

// File: rtl/ifft_result_reader_rise_detect.sv
// One-flop rising-edge detector for the spectral FSM's done level.
// While clr_n_i is low the flop still tracks the live input, so a level
// that is already high when reset releases is not reported as an edge.
module ifft_result_reader_rise_detect (
  input  logic clk_i,
  input  logic clr_n_i,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // Previous-cycle copy of the input; reset loads the live level.
  always_ff @(posedge clk_i) begin
    d_q <= d_i;
  end

  assign rise_o = clr_n_i & d_i & ~d_q;

endmodule

// File: rtl/ifft_result_reader.sv
// ifft_result_reader: on a rising edge of calc_done, reads every bin of the
// spectral result memory in ascending order (one outstanding read at a time)
// and streams each bin to the IFFT over valid/ready, tagging the last bin.
// Optional build macro READ_TIMEOUT_EN adds a read-valid watchdog that
// aborts the frame and raises a sticky rd_error.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no frame in flight; waiting for a calc_done rising edge
// REQ   | one-cycle read request for the current bin address
// WAIT  | address held, waiting for result_read_valid
// PUSH  | bin presented to the IFFT, held until ifft_ready
// DONE  | last bin accepted; one-cycle frame_done, busy drops
module ifft_result_reader
  import ifft_result_reader_pkg::*;
#(
  parameter int ADDR_W  = BIN_ADDR_W,
  parameter int DATA_W  = BIN_DATA_W,
  parameter int N_BINS  = 512,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              calc_done,
  output logic [ADDR_W-1:0] result_address,
  output logic              result_read_enable,
  input  logic              result_read_valid,
  input  logic [DATA_W-1:0] result_data,
  output logic [DATA_W-1:0] ifft_data,
  output logic              ifft_valid,
  input  logic              ifft_ready,
  output logic              ifft_last,
  output logic              busy,
  output logic              frame_done,
  output logic              rd_error
);

  if (N_BINS != (1 << ADDR_W)) begin : g_nbins_chk
    $error("ifft_result_reader: N_BINS must equal 2**ADDR_W");
  end
  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("ifft_result_reader: TIMEOUT must be at least 1");
  end

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_BINS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic              valid_q, valid_d;
  logic              last_q,  last_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic              err_q,   err_d;
  logic              start;

`ifdef READ_TIMEOUT_EN
  // Down-counter loaded on entry to WAIT; terminal count means the
  // read has been outstanding for TIMEOUT cycles.
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             tmr_tc;

  assign tmr_tc = (tmr_q == '0);
`endif

  ifft_result_reader_rise_detect u_rise (
    .clk_i   (clk),
    .clr_n_i (rst_n),
    .d_i     (calc_done),
    .rise_o  (start)
  );

  // Next-state and datapath decode; edges outside IDLE are simply ignored.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
`ifdef READ_TIMEOUT_EN
    tmr_d   = tmr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = '0;
          busy_d  = 1'b1;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        state_d = S_WAIT;
`ifdef READ_TIMEOUT_EN
        tmr_d   = TMR_LOAD;
`endif
      end

      S_WAIT: begin
        if (result_read_valid) begin
          data_d  = result_data;
          valid_d = 1'b1;
          last_d  = (addr_q == LAST_ADDR);
          state_d = S_PUSH;
        end
`ifdef READ_TIMEOUT_EN
        else if (tmr_tc) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          tmr_d   = tmr_q - 1'b1;
        end
`endif
      end

      S_PUSH: begin
        if (ifft_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          // The increment past the last bin is never taken, so the
          // address never wraps inside a frame.
          if (last_q) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = S_REQ;
          end
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef READ_TIMEOUT_EN
      tmr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef READ_TIMEOUT_EN
      tmr_q   <= tmr_d;
`endif
    end
  end

  assign result_address     = addr_q;
  assign result_read_enable = (state_q == S_REQ);
  assign ifft_data          = data_q;
  assign ifft_valid         = valid_q;
  assign ifft_last          = last_q;
  assign busy               = busy_q;
  assign frame_done         = done_q;
`ifdef READ_TIMEOUT_EN
  assign rd_error           = err_q;
`else
  assign rd_error           = 1'b0;
`endif

endmodule

// File: tb/tb_ifft_result_reader.sv
module tb_ifft_result_reader;
  import ifft_result_reader_pkg::*;

  localparam int AW = 9;
  localparam int DW = 36;
  localparam int NB = 512;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          calc_done;
  logic [AW-1:0] result_address;
  logic          result_read_enable;
  logic          result_read_valid;
  logic [DW-1:0] result_data;
  logic [DW-1:0] ifft_data;
  logic          ifft_valid;
  logic          ifft_ready;
  logic          ifft_last;
  logic          busy;
  logic          frame_done;
  logic          rd_error;

  always #5 clk = ~clk;

  ifft_result_reader #(.ADDR_W(AW), .DATA_W(DW), .N_BINS(NB), .TIMEOUT(TO)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .calc_done          (calc_done),
    .result_address     (result_address),
    .result_read_enable (result_read_enable),
    .result_read_valid  (result_read_valid),
    .result_data        (result_data),
    .ifft_data          (ifft_data),
    .ifft_valid         (ifft_valid),
    .ifft_ready         (ifft_ready),
    .ifft_last          (ifft_last),
    .busy               (busy),
    .frame_done         (frame_done),
    .rd_error           (rd_error)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Per-frame stimulus configuration.
  typedef struct {
    int          lat_mode;   // 0: valid 1 cycle after request, 1: delays cycle 1..7
    int          rdy_mode;   // 0: ready tied high, 1: ready pattern 1-0-0-1
    bit          spur;       // inject a stray read_valid while idle
    logic [17:0] salt;
    int          exp_cycles; // start edge to frame_done, or 0 when not checked
  } frame_vec_t;

  frame_vec_t vecs[4];

  int          lat_mode  = 0;
  int          rdy_mode  = 0;
  logic [17:0] salt      = '0;
  bit          spur_req  = 1'b0;
  int          withhold  = -1;
  int          pend      = 0;
  logic [AW-1:0] pend_addr;
  int          req_cnt   = 0;
  int          hs_cnt    = 0;
  int          done_cnt  = 0;
  int          last_cnt  = 0;
  int          done_cyc  = 0;
  int          exp_addr  = 0;
  int          rdy_idx   = 0;
  int          req_w_cyc = 0;
  logic [DW:0] sb_q[$];
  bit          prev_hold = 1'b0;
  logic [DW-1:0] prev_data;
  logic        prev_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] bin_word(input int a, input logic [17:0] s);
    logic [17:0] f;
    f = 18'(a);
    return {f ^ s, f ^ {s[8:0], s[17:9]}};
  endfunction

  // Memory responder, ready driver and output monitor, all evaluated on the
  // falling edge so their values are what the DUT samples at the next rise.
  initial begin : bench
    result_read_valid = 1'b0;
    result_data       = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend              = 0;
        result_read_valid = 1'b0;
        prev_hold         = 1'b0;
      end else begin
        result_read_valid = 1'b0;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            result_read_valid = 1'b1;
            result_data       = bin_word(int'(pend_addr), salt);
          end
        end else if (spur_req) begin
          result_read_valid = 1'b1;
          result_data       = 36'h9_8765_4321;
          spur_req          = 1'b0;
        end

        if (result_read_enable) begin
          check("req_addr", result_address, exp_addr[AW-1:0]);
          check("req_outstanding", pend, 0);
          check("req_in_push", ifft_valid, 1'b0);
          req_cnt++;
          if (int'(result_address) == withhold) begin
            req_w_cyc = cyc;
          end else begin
            pend      = (lat_mode == 1) ? (req_cnt % 7) + 1 : 1;
            pend_addr = result_address;
            sb_q.push_back({(exp_addr == NB - 1), bin_word(exp_addr, salt)});
          end
          exp_addr++;
        end

        ifft_ready = (rdy_mode == 0) ? 1'b1 : ((rdy_idx % 4 == 0) || (rdy_idx % 4 == 3));
        rdy_idx++;

        if (prev_hold) begin
          check("hold_valid", ifft_valid, 1'b1);
          check("hold_data", ifft_data, prev_data);
          check("hold_last", ifft_last, prev_last);
        end
        if (ifft_valid && ifft_ready) begin
          check("sb_nonempty", (sb_q.size() > 0), 1'b1);
          if (sb_q.size() > 0) begin
            logic [DW:0] e;
            e = sb_q.pop_front();
            check("ifft_data", ifft_data, e[DW-1:0]);
            check("ifft_last", ifft_last, e[DW]);
          end
          hs_cnt++;
          if (ifft_last) last_cnt++;
        end
        prev_hold = ifft_valid && !ifft_ready;
        prev_data = ifft_data;
        prev_last = ifft_last;

        if (frame_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic rise_calc_done(output int c0);
    wait_cycles(1);
    calc_done = 1'b0;
    wait_cycles(1);
    calc_done = 1'b1;
    @(posedge clk);
    #1 c0 = cyc;
  endtask

  task automatic wait_done(input int d0, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      wait_cycles(1);
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
    end
    check("frame_done_seen", ok, 1'b1);
  endtask

  task automatic wait_hs(input int h0, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (hs_cnt - h0 >= n) break;
      wait_cycles(1);
    end
    check("hs_reached", (hs_cnt - h0 >= n), 1'b1);
  endtask

  task automatic frame_checks(input int h0, input int r0, input int d0, input int l0);
    check("hs_count", hs_cnt - h0, NB);
    check("req_count", req_cnt - r0, NB);
    check("done_count", done_cnt - d0, 1);
    check("last_count", last_cnt - l0, 1);
    check("sb_drained", sb_q.size(), 0);
  endtask

  initial begin : main
    int h0, r0, d0, l0, c0;
    bit ok;

    vecs[0] = '{lat_mode: 0, rdy_mode: 0, spur: 1'b0, salt: 18'h00000, exp_cycles: 3 * NB + 1};
    vecs[1] = '{lat_mode: 0, rdy_mode: 1, spur: 1'b0, salt: 18'h2A5A5, exp_cycles: 0};
    vecs[2] = '{lat_mode: 1, rdy_mode: 0, spur: 1'b1, salt: 18'h15A5A, exp_cycles: 0};
    vecs[3] = '{lat_mode: 1, rdy_mode: 1, spur: 1'b1, salt: 18'h3FFFF, exp_cycles: 0};

    rst_n      = 1'b0;
    calc_done  = 1'b0;
    ifft_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_valid", ifft_valid, 1'b0);
    check("rst_last", ifft_last, 1'b0);
    check("rst_rden", result_read_enable, 1'b0);
    check("rst_addr", result_address, '0);
    check("rst_done", frame_done, 1'b0);
    check("rst_err", rd_error, 1'b0);
    check("rst_data", ifft_data, '0);
    wait_cycles(1);
    rst_n = 1'b1;
    wait_cycles(2);

    for (int v = 0; v < 4; v++) begin
      lat_mode = vecs[v].lat_mode;
      rdy_mode = vecs[v].rdy_mode;
      salt     = vecs[v].salt;
      exp_addr = 0;
      rdy_idx  = 0;
      h0 = hs_cnt; r0 = req_cnt; d0 = done_cnt; l0 = last_cnt;
      if (vecs[v].spur) begin
        spur_req = 1'b1;
        wait_cycles(3);
        check("spur_idle_busy", busy, 1'b0);
        check("spur_idle_valid", ifft_valid, 1'b0);
      end
      rise_calc_done(c0);
      check("busy_after_start", busy, 1'b1);
      wait_done(d0, 8000);
      if (vecs[v].exp_cycles > 0) check("frame_cycles", done_cyc - c0, vecs[v].exp_cycles);
      wait_cycles(1);
      check("done_pulse_width", frame_done, 1'b0);
      check("busy_after_done", busy, 1'b0);
      if (vecs[v].spur) begin
        spur_req = 1'b1;
        wait_cycles(3);
      end
      frame_checks(h0, r0, d0, l0);
      check("rd_error_off", rd_error, 1'b0);
    end

    // Second edge mid-frame is ignored; a held-high level starts nothing.
    lat_mode = 0; rdy_mode = 0; salt = 18'h0C3C3; exp_addr = 0;
    h0 = hs_cnt; r0 = req_cnt; d0 = done_cnt; l0 = last_cnt;
    rise_calc_done(c0);
    wait_hs(h0, 100, 2000);
    calc_done = 1'b0;
    wait_cycles(1);
    calc_done = 1'b1;
    wait_done(d0, 8000);
    frame_checks(h0, r0, d0, l0);
    wait_cycles(40);
    check("held_high_no_req", req_cnt - r0, NB);
    check("held_high_busy", busy, 1'b0);
    check("held_high_no_done", done_cnt - d0, 1);
    exp_addr = 0;
    h0 = hs_cnt; r0 = req_cnt; d0 = done_cnt; l0 = last_cnt;
    rise_calc_done(c0);
    check("restart_busy", busy, 1'b1);
    wait_done(d0, 8000);
    frame_checks(h0, r0, d0, l0);

    // Reset in the middle of a frame.
    salt = 18'h1E1E1; exp_addr = 0;
    h0 = hs_cnt; d0 = done_cnt;
    rise_calc_done(c0);
    wait_hs(h0, 300, 2000);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_valid", ifft_valid, 1'b0);
    check("midrst_last", ifft_last, 1'b0);
    check("midrst_rden", result_read_enable, 1'b0);
    check("midrst_addr", result_address, '0);
    check("midrst_data", ifft_data, '0);
    check("midrst_done", frame_done, 1'b0);
    wait_cycles(1);
    rst_n = 1'b1;
    sb_q.delete();
    wait_cycles(20);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_no_autostart", busy, 1'b0);
    exp_addr = 0;
    h0 = hs_cnt; r0 = req_cnt; d0 = done_cnt; l0 = last_cnt;
    rise_calc_done(c0);
    wait_done(d0, 8000);
    frame_checks(h0, r0, d0, l0);

`ifdef READ_TIMEOUT_EN
    // Withheld read for bin 5 trips the watchdog.
    salt = 18'h01234; exp_addr = 0; withhold = 5;
    d0 = done_cnt; l0 = last_cnt;
    rise_calc_done(c0);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      wait_cycles(1);
      if (rd_error) begin
        ok = 1'b1;
        break;
      end
    end
    check("timeout_seen", ok, 1'b1);
    check("timeout_latency", cyc - req_w_cyc, TO + 1);
    check("timeout_busy", busy, 1'b0);
    wait_cycles(10);
    check("timeout_no_done", done_cnt - d0, 0);
    check("timeout_no_last", last_cnt - l0, 0);
    withhold = -1;
    sb_q.delete();
    exp_addr = 0;
    h0 = hs_cnt; r0 = req_cnt; d0 = done_cnt; l0 = last_cnt;
    rise_calc_done(c0);
    wait_done(d0, 8000);
    frame_checks(h0, r0, d0, l0);
    check("rd_error_sticky", rd_error, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rd_error_cleared", rd_error, 1'b0);
    wait_cycles(1);
    rst_n = 1'b1;
`endif

    wait_cycles(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #900000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
